video_timing_recover: RTL and testbench

VIDEO_TIMING_RECOVER -- requirements
Module: video_timing_recover

---
 rtl/video_timing_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 31 +++
 rtl/video_timing_recover.sv | 178 +++++++++++++++++
 tb/tb_video_timing_recover.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
`default_nettype none
// video_timing_pkg: shared FSM state and lock-loss reason encodings for video_timing_recover.
// Revision 1.0
package video_timing_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RSN_NONE       = 3'd0,
    RSN_WIDTH      = 3'd1,
    RSN_PERIOD     = 3'd2,
    RSN_HS_MISSING = 3'd3,
    RSN_AD_IN_VS   = 3'd4,
    RSN_LINES      = 3'd5
  } reason_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// sync_edge_detect: registers one input and flags rising/falling edges against its previous sample.
// Revision 1.0
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= d_i;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/video_timing_recover.sv
`default_nettype none
// video_timing_recover: recovers pixel/line counts from hs/vs/ad, measures timing and tracks lock.
// Revision 1.0
module video_timing_recover
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int TOTAL_WIDTH     = 1650,
  parameter int ACTIVE_LINES    = 720,
  parameter int LOCK_FRAMES     = 4
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_n_in,
  input  logic                              hs_in,
  input  logic                              vs_in,
  input  logic                              ad_in,
  output logic [$clog2(TOTAL_WIDTH)-1:0]    hcount_out,
  output logic [$clog2(ACTIVE_LINES+1)-1:0] vcount_out,
  output logic                              ad_out,
  output logic                              nf_out,
  output logic                              locked_out,
  output logic                              err_out,
  output logic [$clog2(TOTAL_WIDTH+1)-1:0]  meas_width_out,
  output logic [$clog2(TOTAL_WIDTH+1)-1:0]  meas_period_out,
  output logic [$clog2(ACTIVE_LINES+1)-1:0] meas_lines_out
);

  localparam int HW = $clog2(TOTAL_WIDTH);
  localparam int PW = $clog2(TOTAL_WIDTH + 1);
  localparam int VW = $clog2(ACTIVE_LINES + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [PW-1:0] C_ACT_W = PW'(ACTIVE_H_PIXELS);
  localparam logic [PW-1:0] C_TOT   = PW'(TOTAL_WIDTH);
  localparam logic [VW-1:0] C_LINES = VW'(ACTIVE_LINES);
  localparam logic [GW-1:0] C_LOCK  = GW'(LOCK_FRAMES);

  logic hs_sync, hs_rise, hs_fall;
  logic vs_sync, vs_rise, vs_fall;
  logic ad_sync, ad_rise, ad_fall;
  logic unused_sync;

  sync_edge_detect u_hs (.clk_i(pixel_clk_in), .rst_ni(rst_n_in), .d_i(hs_in),
                         .q_o(hs_sync), .rise_o(hs_rise), .fall_o(hs_fall));
  sync_edge_detect u_vs (.clk_i(pixel_clk_in), .rst_ni(rst_n_in), .d_i(vs_in),
                         .q_o(vs_sync), .rise_o(vs_rise), .fall_o(vs_fall));
  sync_edge_detect u_ad (.clk_i(pixel_clk_in), .rst_ni(rst_n_in), .d_i(ad_in),
                         .q_o(ad_sync), .rise_o(ad_rise), .fall_o(ad_fall));

  assign unused_sync = hs_sync ^ hs_fall ^ vs_fall;

  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [PW-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d, period_cap;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [PW-1:0] meas_width_q, meas_width_d;
  logic [PW-1:0] meas_period_q, meas_period_d;
  logic [VW-1:0] meas_lines_q, meas_lines_d;
  logic          hs_seen_q, hs_seen_d;
  logic          frame_dirty_q, frame_dirty_d;
  reason_e       reason;
  logic          dirty;

  // Saturated counter means the span already exceeds a full line, so report exactly TOTAL_WIDTH.
  assign period_cap = (pcnt_q == C_TOT) ? C_TOT : pcnt_q + 1'b1;
  assign good_inc   = good_q + 1'b1;

  always_comb begin
    reason = RSN_NONE;
    if (pcnt_q == C_TOT)                                  reason = RSN_HS_MISSING;
    else if (hs_rise && hs_seen_q && period_cap != C_TOT) reason = RSN_PERIOD;
    else if (ad_fall && wcnt_q != C_ACT_W)                reason = RSN_WIDTH;
    else if (ad_sync && vs_sync)                          reason = RSN_AD_IN_VS;
    else if (vs_rise && vcnt_q != C_LINES)                reason = RSN_LINES;
  end

  assign dirty = (reason != RSN_NONE);

  always_comb begin
    hcount_d = hcount_q;
    if (ad_rise)                         hcount_d = '0;
    else if (ad_sync && hcount_q != '1)  hcount_d = hcount_q + 1'b1;

    wcnt_d = wcnt_q;
    if (ad_rise)                         wcnt_d = PW'(1);
    else if (ad_sync && wcnt_q != '1)    wcnt_d = wcnt_q + 1'b1;

    pcnt_d = pcnt_q;
    if (hs_rise)                         pcnt_d = '0;
    else if (pcnt_q != C_TOT)            pcnt_d = pcnt_q + 1'b1;

    vcnt_d = vcnt_q;
    if (vs_rise)                         vcnt_d = '0;
    else if (ad_fall && vcnt_q != '1)    vcnt_d = vcnt_q + 1'b1;

    meas_width_d  = ad_fall ? wcnt_q : meas_width_q;
    meas_period_d = (hs_rise && hs_seen_q) ? period_cap : meas_period_q;
    meas_lines_d  = vs_rise ? vcnt_q : meas_lines_q;
    frame_dirty_d = vs_rise ? 1'b0 : (frame_dirty_q | dirty);
    // Dropping out of lock restarts the period measurement from scratch.
    hs_seen_d     = (state_q == ST_LOCKED && dirty) ? 1'b0 : (hs_seen_q | hs_rise);
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_rise) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (vs_rise) begin
          if (frame_dirty_q || dirty) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc == C_LOCK) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (dirty) begin
          state_d = ST_SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_SEARCH;
      good_q        <= '0;
      hcount_q      <= '0;
      wcnt_q        <= '0;
      pcnt_q        <= '0;
      vcnt_q        <= '0;
      meas_width_q  <= '0;
      meas_period_q <= '0;
      meas_lines_q  <= '0;
      hs_seen_q     <= 1'b0;
      frame_dirty_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      hcount_q      <= hcount_d;
      wcnt_q        <= wcnt_d;
      pcnt_q        <= pcnt_d;
      vcnt_q        <= vcnt_d;
      meas_width_q  <= meas_width_d;
      meas_period_q <= meas_period_d;
      meas_lines_q  <= meas_lines_d;
      hs_seen_q     <= hs_seen_d;
      frame_dirty_q <= frame_dirty_d;
    end
  end

  assign hcount_out      = hcount_d;
  assign vcount_out      = vcnt_q;
  assign ad_out          = ad_sync;
  assign nf_out          = vs_rise;
  assign locked_out      = (state_q == ST_LOCKED) && !dirty;
  assign err_out         = (state_q == ST_LOCKED) && dirty;
  assign meas_width_out  = meas_width_q;
  assign meas_period_out = meas_period_q;
  assign meas_lines_out  = meas_lines_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_recover.sv
`default_nettype none
// tb_video_timing_recover: directed, table-driven self-checking bench for video_timing_recover.
// Revision 1.0
module tb_video_timing_recover;

  logic       pixel_clk_in = 1'b0;
  logic       rst_n_in     = 1'b0;
  logic       hs_in        = 1'b0;
  logic       vs_in        = 1'b0;
  logic       ad_in        = 1'b0;
  logic [3:0] hcount_out;
  logic [2:0] vcount_out;
  logic       ad_out, nf_out, locked_out, err_out;
  logic [4:0] meas_width_out, meas_period_out;
  logic [2:0] meas_lines_out;

  int n_vec   = 0;
  int n_bad   = 0;
  int err_cnt = 0;
  int fidx    = 0;

  typedef struct {
    logic hs, vs, ad;
    logic e_ad;
    int   e_hc, e_vc;
    logic e_nf, e_lk, e_er;
  } vec_t;

  vec_t vecs[16];

  video_timing_recover #(
    .ACTIVE_H_PIXELS(8), .TOTAL_WIDTH(16), .ACTIVE_LINES(4), .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk_in(pixel_clk_in), .rst_n_in(rst_n_in),
    .hs_in(hs_in), .vs_in(vs_in), .ad_in(ad_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .ad_out(ad_out),
    .nf_out(nf_out), .locked_out(locked_out), .err_out(err_out),
    .meas_width_out(meas_width_out), .meas_period_out(meas_period_out),
    .meas_lines_out(meas_lines_out)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  always @(negedge pixel_clk_in) if (err_out) err_cnt = err_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (frame %0d): got %0d, expected %0d", nm, fidx, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic v, input logic a);
    hs_in = h; vs_in = v; ad_in = a;
    @(posedge pixel_clk_in);
    #1;
  endtask

  // Stimulus frame: 8 lines of 16 clocks; hs on clocks 10-11, vs on lines 5-6.
  function automatic logic hs_at(input int l, input int c);
    return !(fidx == 7 && l == 2) && (c == 10 || c == 11);
  endfunction

  function automatic logic vs_at(input int l);
    return (l == 5 || l == 6);
  endfunction

  function automatic logic ad_at(input int l, input int c);
    int nact;
    int npix;
    nact = (fidx == 8) ? 3 : 4;
    npix = (fidx == 4 && l == 2) ? 7 : 8;
    return (l < nact) && (c < npix);
  endfunction

  task automatic hook(input int l, input int c);
    if (fidx == 0 && l == 0 && c == 0) begin
      chk("first ad_out", int'(ad_out), 1);
      chk("first hcount", int'(hcount_out), 0);
      chk("first vcount", int'(vcount_out), 0);
      chk("first locked", int'(locked_out), 0);
    end
    if (fidx == 1 && l == 5 && c == 1) chk("no lock at 2nd vs", int'(locked_out), 0);
    if (fidx == 2 && l == 5 && c == 0) begin
      chk("nf at vs", int'(nf_out), 1);
      chk("lock before 3rd vs acts", int'(locked_out), 0);
    end
    if (fidx == 2 && l == 5 && c == 1) begin
      chk("lock at 3rd vs", int'(locked_out), 1);
      chk("nf single cycle", int'(nf_out), 0);
    end
    if (fidx == 3 && l == 0 && c == 9) begin
      chk("meas_width", int'(meas_width_out), 8);
      chk("meas_period", int'(meas_period_out), 16);
      chk("meas_lines", int'(meas_lines_out), 4);
    end
    if (fidx == 3 && l == 3 && c == 7) begin
      chk("last pixel hcount", int'(hcount_out), 7);
      chk("last line vcount", int'(vcount_out), 3);
    end
    if (fidx == 3 && l == 7 && c == 15) begin
      chk("no err while clean", err_cnt, 0);
      chk("still locked", int'(locked_out), 1);
    end
    if (fidx == 4 && l == 2 && c == 6) begin
      chk("short line pre locked", int'(locked_out), 1);
      chk("short line pre err", int'(err_out), 0);
    end
    if (fidx == 4 && l == 2 && c == 7) begin
      chk("short line err", int'(err_out), 1);
      chk("short line unlock", int'(locked_out), 0);
    end
    if (fidx == 4 && l == 2 && c == 8) begin
      chk("short line err one cycle", int'(err_out), 0);
      chk("short line stays unlocked", int'(locked_out), 0);
      chk("short line width", int'(meas_width_out), 7);
    end
    if (fidx == 4 && l == 7 && c == 15) chk("err pulses after short line", err_cnt, 1);
    if (fidx == 5 && l == 5 && c == 1) chk("relock not yet f5", int'(locked_out), 0);
    if (fidx == 6 && l == 5 && c == 0) chk("relock not yet f6", int'(locked_out), 0);
    if (fidx == 6 && l == 5 && c == 1) chk("relock after 3 vs", int'(locked_out), 1);
    if (fidx == 7 && l == 2 && c == 10) begin
      chk("no hs pre locked", int'(locked_out), 1);
      chk("no hs pre err", int'(err_out), 0);
    end
    if (fidx == 7 && l == 2 && c == 11) begin
      chk("no hs err", int'(err_out), 1);
      chk("no hs unlock", int'(locked_out), 0);
    end
    if (fidx == 7 && l == 2 && c == 12) chk("no hs err one cycle", int'(err_out), 0);
    if (fidx == 7 && l == 7 && c == 15) begin
      chk("err pulses after no hs", err_cnt, 2);
      chk("search after no hs", int'(locked_out), 0);
    end
    if (fidx == 8 && l == 5 && c == 1) begin
      chk("three line count", int'(meas_lines_out), 3);
      chk("no lock after dirty frame", int'(locked_out), 0);
    end
    if (fidx == 9 && l == 5 && c == 1) begin
      chk("one clean after dirty", int'(locked_out), 0);
      chk("line count restored", int'(meas_lines_out), 4);
    end
    if (fidx == 10 && l == 5 && c == 0) chk("lock pending f10", int'(locked_out), 0);
    if (fidx == 10 && l == 5 && c == 1) chk("lock after 2 clean", int'(locked_out), 1);
    if (fidx == 10 && l == 7 && c == 15) chk("no err outside lock", err_cnt, 2);
  endtask

  task automatic run_lines(input int l0, input int l1);
    for (int l = l0; l <= l1; l++) begin
      for (int c = 0; c < 16; c++) begin
        step(hs_at(l, c), vs_at(l), ad_at(l, c));
        hook(l, c);
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " hcount"}, int'(hcount_out), 0);
    chk({nm, " vcount"}, int'(vcount_out), 0);
    chk({nm, " ad_out"}, int'(ad_out), 0);
    chk({nm, " nf"}, int'(nf_out), 0);
    chk({nm, " locked"}, int'(locked_out), 0);
    chk({nm, " err"}, int'(err_out), 0);
    chk({nm, " meas_width"}, int'(meas_width_out), 0);
    chk({nm, " meas_period"}, int'(meas_period_out), 0);
    chk({nm, " meas_lines"}, int'(meas_lines_out), 0);
  endtask

  initial begin
    // Line 1 of a locked frame: {hs, vs, ad, ad_out, hcount, vcount, nf, locked, err}
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5, 1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6, 1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7, 1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 2, 1'b0, 1'b1, 1'b0};

    // Inputs toggling while held in reset must not reach the outputs.
    rst_n_in = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk_all_zero("in reset");
    hs_in = 1'b0; vs_in = 1'b0; ad_in = 1'b0;
    #4;
    rst_n_in = 1'b1;

    for (int f = 0; f < 3; f++) begin
      fidx = f;
      run_lines(0, 7);
    end

    fidx = 3;
    run_lines(0, 0);
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].hs, vecs[i].vs, vecs[i].ad);
      chk($sformatf("vec%0d ad_out", i), int'(ad_out), int'(vecs[i].e_ad));
      chk($sformatf("vec%0d hcount", i), int'(hcount_out), vecs[i].e_hc);
      chk($sformatf("vec%0d vcount", i), int'(vcount_out), vecs[i].e_vc);
      chk($sformatf("vec%0d nf", i), int'(nf_out), int'(vecs[i].e_nf));
      chk($sformatf("vec%0d locked", i), int'(locked_out), int'(vecs[i].e_lk));
      chk($sformatf("vec%0d err", i), int'(err_out), int'(vecs[i].e_er));
    end
    run_lines(2, 7);

    for (int f = 4; f < 11; f++) begin
      fidx = f;
      run_lines(0, 7);
    end

    // Asynchronous reset mid-line while locked.
    fidx = 11;
    run_lines(0, 0);
    for (int c = 0; c < 4; c++) step(hs_at(1, c), 1'b0, ad_at(1, c));
    chk("pre-reset ad_out", int'(ad_out), 1);
    chk("pre-reset hcount", int'(hcount_out), 3);
    chk("pre-reset vcount", int'(vcount_out), 1);
    chk("pre-reset locked", int'(locked_out), 1);
    rst_n_in = 1'b0;
    #1;
    chk_all_zero("async reset");
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    #4;
    rst_n_in = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("no err on reset", err_cnt, 2);
    chk("unlocked after reset", int'(locked_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
